// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle ALU plus HI/LO write generation.
// DIV/DIVU use a multi-cycle restoring divider that stalls the pipeline.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] link_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        is_in_delayslot_o,
  output logic        stallreq
);

  localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011,
                         SEL_ARITH = 3'b100, SEL_JB = 3'b110;
  localparam logic [7:0] OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110,
                         OP_NOR = 8'b00100111, OP_SLL = 8'b01111100, OP_SRL = 8'b00000010,
                         OP_SRA = 8'b00000011, OP_ADDU = 8'b00100001, OP_SUBU = 8'b00100011,
                         OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011, OP_MFHI = 8'b00010000,
                         OP_MTHI = 8'b00010001, OP_MFLO = 8'b00010010, OP_MTLO = 8'b00010011,
                         OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011;
  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t     state;
  logic [CW-1:0]  count;
  logic [31:0]    dvd, dvs, quo, rem;
  logic           neg_q, neg_r;

  logic        is_div, is_signed;
  logic [31:0] abs1, abs2, quo_final, rem_final;
  logic [32:0] trial;
  logic        unused_inst;

  assign unused_inst = ^inst_i;
  assign is_div      = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed   = (aluop_i == OP_DIV);
  assign abs1        = (is_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign abs2        = (is_signed && reg2_i[31]) ? -reg2_i : reg2_i;
  assign trial       = {rem, dvd[31]};
  assign quo_final   = neg_q ? -quo : quo;
  assign rem_final   = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      dvd   <= '0;
      dvs   <= '0;
      quo   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            dvd   <= abs1;
            dvs   <= abs2;
            count <= '0;
            if (reg2_i == 32'd0) begin
              // Divide by zero reports raw operands, so no sign fix-up applies
              quo   <= 32'hFFFF_FFFF;
              rem   <= reg1_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else begin
              quo   <= '0;
              rem   <= '0;
              neg_q <= is_signed && (reg1_i[31] ^ reg2_i[31]);
              neg_r <= is_signed && reg1_i[31];
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (trial >= {1'b0, dvs}) begin
            rem <= 32'(trial - {1'b0, dvs});
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          dvd   <= {dvd[30:0], 1'b0};
          count <= count + CW'(1);
          if (count == CW'(DIV_CYCLES - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o              = '0;
    wreg_o            = 1'b0;
    wdata_o           = '0;
    whilo_o           = 1'b0;
    hi_o              = '0;
    lo_o              = '0;
    is_in_delayslot_o = 1'b0;
    stallreq          = 1'b0;
    if (!rst) begin
      wd_o              = wd_i;
      wreg_o            = wreg_i;
      is_in_delayslot_o = is_in_delayslot_i;
      case (alusel_i)
        SEL_LOGIC: case (aluop_i)
          OP_AND:  wdata_o = reg1_i & reg2_i;
          OP_OR:   wdata_o = reg1_i | reg2_i;
          OP_XOR:  wdata_o = reg1_i ^ reg2_i;
          OP_NOR:  wdata_o = ~(reg1_i | reg2_i);
          default: wdata_o = '0;
        endcase
        SEL_SHIFT: case (aluop_i)
          OP_SLL:  wdata_o = reg2_i << reg1_i[4:0];
          OP_SRL:  wdata_o = reg2_i >> reg1_i[4:0];
          OP_SRA:  wdata_o = $signed(reg2_i) >>> reg1_i[4:0];
          default: wdata_o = '0;
        endcase
        SEL_ARITH: case (aluop_i)
          OP_ADDU: wdata_o = reg1_i + reg2_i;
          OP_SUBU: wdata_o = reg1_i - reg2_i;
          OP_SLT:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
          OP_SLTU: wdata_o = {31'd0, reg1_i < reg2_i};
          default: wdata_o = '0;
        endcase
        SEL_MOVE: case (aluop_i)
          OP_MFHI: wdata_o = hi_i;
          OP_MFLO: wdata_o = lo_i;
          default: wdata_o = '0;
        endcase
        SEL_JB:  wdata_o = link_addr_i;
        default: wdata_o = '0;
      endcase
      if (!flush) begin
        stallreq = (state == S_BUSY) || (state == S_IDLE && is_div);
        if (state == S_DONE) begin
          whilo_o = 1'b1;
          hi_o    = rem_final;
          lo_o    = quo_final;
        end else if (aluop_i == OP_MTHI) begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_i;
        end else if (aluop_i == OP_MTLO) begin
          whilo_o = 1'b1;
          hi_o    = hi_i;
          lo_o    = reg1_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: driver pushes reference results, monitor
// retires them whenever the stage stops stalling and checks stall length.
module tb_ex_stage;

  localparam logic [2:0] SEL_NOP = 3'b000, SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010,
                         SEL_MOVE = 3'b011, SEL_ARITH = 3'b100, SEL_JB = 3'b110;
  localparam logic [7:0] OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110,
                         OP_NOR = 8'b00100111, OP_SLL = 8'b01111100, OP_SRL = 8'b00000010,
                         OP_SRA = 8'b00000011, OP_ADDU = 8'b00100001, OP_SUBU = 8'b00100011,
                         OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011, OP_MFHI = 8'b00010000,
                         OP_MTHI = 8'b00010001, OP_MFLO = 8'b00010010, OP_MTLO = 8'b00010011,
                         OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011, OP_JAL = 8'b01010000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [2:0]  alusel_i = '0;
  logic [31:0] reg1_i = '0, reg2_i = '0, link_addr_i = '0, inst_i = '0, hi_i = '0, lo_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0, is_in_delayslot_i = 1'b0;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, is_in_delayslot_o, stallreq;
  logic [31:0] wdata_o, hi_o, lo_o;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .link_addr_i(link_addr_i), .is_in_delayslot_i(is_in_delayslot_i), .inst_i(inst_i),
    .hi_i(hi_i), .lo_i(lo_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .is_in_delayslot_o(is_in_delayslot_o),
    .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata, hi, lo;
    logic [4:0]  wd;
    logic        wreg, whilo, ds;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0, passed = 0;
  int issued = 0, retired = 0, lat_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (retired %0d)", name, act, exp, retired);
  endtask

  // Reference: results straight from the instruction semantics
  function automatic exp_t model(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] r1, r2, hi, lo, link,
                                 input logic [4:0] wd, input logic wreg, ds);
    exp_t   m;
    longint a, b;
    m.wd = wd; m.wreg = wreg; m.ds = ds;
    m.wdata = 0; m.whilo = 0; m.hi = 0; m.lo = 0; m.lat = 0;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) m.wdata = r1 & r2;
      if (op == OP_OR)  m.wdata = r1 | r2;
      if (op == OP_XOR) m.wdata = r1 ^ r2;
      if (op == OP_NOR) m.wdata = ~(r1 | r2);
    end else if (sel == SEL_SHIFT) begin
      a = longint'($signed(r2));
      if (op == OP_SLL) m.wdata = 32'(r2 * (64'd1 << r1[4:0]));
      if (op == OP_SRL) m.wdata = r2 / (32'd1 << r1[4:0]);
      if (op == OP_SRA) m.wdata = 32'(a >>> r1[4:0]);
    end else if (sel == SEL_ARITH) begin
      a = longint'($signed(r1)); b = longint'($signed(r2));
      if (op == OP_ADDU) m.wdata = 32'(64'(r1) + 64'(r2));
      if (op == OP_SUBU) m.wdata = 32'(64'(r1) - 64'(r2));
      if (op == OP_SLT)  m.wdata = (a < b) ? 1 : 0;
      if (op == OP_SLTU) m.wdata = (64'(r1) < 64'(r2)) ? 1 : 0;
    end else if (sel == SEL_MOVE) begin
      if (op == OP_MFHI) m.wdata = hi;
      if (op == OP_MFLO) m.wdata = lo;
    end else if (sel == SEL_JB) m.wdata = link;
    if (op == OP_MTHI) begin m.whilo = 1; m.hi = r1; m.lo = lo; end
    if (op == OP_MTLO) begin m.whilo = 1; m.hi = hi; m.lo = r1; end
    if (op == OP_DIV || op == OP_DIVU) begin
      m.whilo = 1;
      if (r2 == 0) begin
        m.lo = 32'hFFFF_FFFF; m.hi = r1; m.lat = 1;
      end else begin
        m.lat = 33;
        if (op == OP_DIVU) begin
          m.lo = r1 / r2; m.hi = r1 % r2;
        end else begin
          a = longint'($signed(r1)); b = longint'($signed(r2));
          m.lo = 32'(a / b); m.hi = 32'(a % b);
        end
      end
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wdata", wdata_o, 0);
      chk("rst_wd", 32'(wd_o), 0);
      chk("rst_wreg", 32'(wreg_o), 0);
      chk("rst_whilo", 32'(whilo_o), 0);
      chk("rst_hi", hi_o, 0);
      chk("rst_lo", lo_o, 0);
      chk("rst_ds", 32'(is_in_delayslot_o), 0);
      chk("rst_stall", 32'(stallreq), 0);
    end else if (issued != retired) begin
      if (stallreq) lat_cnt++;
      else begin
        e = sb.pop_front();
        chk("wdata", wdata_o, e.wdata);
        chk("wd", 32'(wd_o), 32'(e.wd));
        chk("wreg", 32'(wreg_o), 32'(e.wreg));
        chk("ds", 32'(is_in_delayslot_o), 32'(e.ds));
        chk("whilo", 32'(whilo_o), 32'(e.whilo));
        chk("hi", hi_o, e.hi);
        chk("lo", lo_o, e.lo);
        chk("stall_cycles", lat_cnt, e.lat);
        lat_cnt = 0;
        retired++;
      end
    end else begin
      chk("idle_whilo", 32'(whilo_o), 0);
    end
  end

  task automatic set_nop();
    aluop_i = '0; alusel_i = SEL_NOP; reg1_i = '0; reg2_i = '0; link_addr_i = '0;
    hi_i = '0; lo_i = '0; wd_i = '0; wreg_i = 1'b0; is_in_delayslot_i = 1'b0; inst_i = '0;
  endtask

  task automatic apply(input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, r2, link);
    aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; link_addr_i = link;
    hi_i = $urandom; lo_i = $urandom; wd_i = 5'($urandom); wreg_i = 1'($urandom);
    is_in_delayslot_i = 1'($urandom); inst_i = $urandom;
  endtask

  task automatic push_current();
    sb.push_back(model(aluop_i, alusel_i, reg1_i, reg2_i, hi_i, lo_i, link_addr_i,
                       wd_i, wreg_i, is_in_delayslot_i));
    issued++;
  endtask

  task automatic wait_retire();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (retired == issued) return;
    end
    $display("FAIL retire_timeout: retired %0d expected %0d", retired, issued);
    $fatal(1, "no retirement within cycle budget");
  endtask

  task automatic run(input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] r1, r2, link);
    @(posedge clk); #1;
    apply(op, sel, r1, r2, link);
    push_current();
    wait_retire();
    @(posedge clk); #1;
    set_nop();
  endtask

  task automatic run_random_alu();
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1, r2;
    case ($urandom_range(0, 16))
      0: begin op = OP_AND;  sel = SEL_LOGIC; end
      1: begin op = OP_OR;   sel = SEL_LOGIC; end
      2: begin op = OP_XOR;  sel = SEL_LOGIC; end
      3: begin op = OP_NOR;  sel = SEL_LOGIC; end
      4: begin op = OP_SLL;  sel = SEL_SHIFT; end
      5: begin op = OP_SRL;  sel = SEL_SHIFT; end
      6: begin op = OP_SRA;  sel = SEL_SHIFT; end
      7: begin op = OP_ADDU; sel = SEL_ARITH; end
      8: begin op = OP_SUBU; sel = SEL_ARITH; end
      9: begin op = OP_SLT;  sel = SEL_ARITH; end
      10: begin op = OP_SLTU; sel = SEL_ARITH; end
      11: begin op = OP_MFHI; sel = SEL_MOVE; end
      12: begin op = OP_MFLO; sel = SEL_MOVE; end
      13: begin op = OP_MTHI; sel = SEL_NOP; end
      14: begin op = OP_MTLO; sel = SEL_NOP; end
      15: begin op = OP_JAL;  sel = SEL_JB; end
      default: begin op = OP_ADDU; sel = 3'b111; end
    endcase
    r1 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    r2 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    run(op, sel, r1, r2, $urandom);
  endtask

  task automatic run_random_div();
    logic [31:0] r1, r2;
    r1 = $urandom;
    case ($urandom_range(0, 3))
      0: r2 = 32'(($urandom_range(1, 20)));
      1: r2 = -32'($urandom_range(1, 20));
      2: r2 = 32'd0;
      default: r2 = $urandom;
    endcase
    run($urandom_range(0, 1) ? OP_DIV : OP_DIVU, SEL_NOP, r1, r2, 0);
  endtask

  initial begin
    // Non-zero inputs during reset make the forced-zero outputs meaningful
    apply(OP_MTHI, SEL_JB, 32'h1234, 32'h5678, 32'h0000_1008);
    wd_i = 5'd9; wreg_i = 1'b1; is_in_delayslot_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 set_nop();
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 0);
    run(OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 0);
    run(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 0);
    run(OP_SRA,  SEL_SHIFT, 32'd4, 32'h8000_0000, 0);
    run(OP_JAL,  SEL_JB,    32'd0, 32'd0, 32'h0000_1008);
    run(OP_DIVU, SEL_NOP,   32'd100, 32'd7, 0);
    run(OP_DIV,  SEL_NOP,   -32'd7, 32'd2, 0);
    run(OP_DIV,  SEL_NOP,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(OP_DIV,  SEL_NOP,   32'd5, 32'd0, 0);

    // Flush twelve cycles into a divide: that cycle retires with no HI/LO write
    @(posedge clk); #1;
    apply(OP_DIV, SEL_NOP, 32'd1000, 32'd3, 0);
    e = model(aluop_i, alusel_i, reg1_i, reg2_i, hi_i, lo_i, link_addr_i,
              wd_i, wreg_i, is_in_delayslot_i);
    e.whilo = 0; e.hi = 0; e.lo = 0; e.lat = 12;
    sb.push_back(e);
    issued++;
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    wait_retire();
    @(posedge clk); #1;
    flush = 1'b0;
    set_nop();
    run(OP_DIVU, SEL_NOP, 32'd9, 32'd3, 0);

    // Reset at count 10 of a divide; this divide never retires
    @(posedge clk); #1;
    apply(OP_DIVU, SEL_NOP, 32'd77, 32'd5, 0);
    wd_i = 5'd3; wreg_i = 1'b1; is_in_delayslot_i = 1'b1;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 set_nop();
    rst = 1'b0;
    repeat (40) @(posedge clk);
    run(OP_DIVU, SEL_NOP, 32'd9, 32'd3, 0);

    for (int i = 0; i < 60; i++) run_random_alu();
    for (int i = 0; i < 12; i++) run_random_div();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the MIPS32 pipeline; consumes the operands and control held in the ID/EX pipeline register.
- Produces the register write-back data and the HI/LO write request for the EX/MEM register.
- Contains a 32-iteration radix-2 restoring divider for DIV/DIVU. It holds the pipeline through stallreq while dividing.
- All other operations are single-cycle combinational.

Parameters:
DIV_CYCLES, 32, number of BUSY iterations (one quotient bit per cycle; must equal data width)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  pipeline flush; aborts any divide
aluop_i  in  8  ALU operation code (defines.vh encodings)
alusel_i  in  3  result-class select
reg1_i  in  32  operand 1 (rs value / shamt source)
reg2_i  in  32  operand 2 (rt value / immediate)
wd_i  in  5  destination register address
wreg_i  in  1  destination write enable
link_addr_i  in  32  return address for link jumps/branches
is_in_delayslot_i  in  1  current instruction is in a delay slot
inst_i  in  32  raw instruction word
hi_i  in  32  current HI (already forwarded)
lo_i  in  32  current LO (already forwarded)
wd_o  out  5  destination address to EX/MEM
wreg_o  out  1  write enable to EX/MEM
wdata_o  out  32  write-back data
whilo_o  out  1  HI/LO write enable
hi_o  out  32  HI write value
lo_o  out  32  LO write value
is_in_delayslot_o  out  1  pass-through of is_in_delayslot_i
stallreq  out  1  request to stall IF/ID/EX (held high during divide)

Behaviour:
- Encodings:
  - alusel: LOGIC=001, SHIFT=010, MOVE=011, ARITH=100, JUMP_BRANCH=110.
  - aluop: AND=00100100, OR=00100101, XOR=00100110, NOR=00100111, SLL=01111100, SRL=00000010, SRA=00000011, ADDU=00100001, SUBU=00100011, SLT=00101010, SLTU=00101011, MFHI=00010000, MTHI=00010001, MFLO=00010010, MTLO=00010011, DIV=00011010, DIVU=00011011.
- Combinational path (rst low):
  - LOGIC: bitwise AND, OR, XOR or NOR of reg1 and reg2.
  - SHIFT: reg2 shifted by reg1[4:0]. SRA sign-fills.
  - ARITH: ADDU/SUBU wrap modulo 2^32 with no overflow trap. SLT/SLTU give 1 or 0 in bit 0.
  - MOVE: MFHI gives hi_i; MFLO gives lo_i.
  - JUMP_BRANCH: gives link_addr_i.
  - Any other alusel: wdata_o = 0.
  - wd_o = wd_i and wreg_o = wreg_i.
- HI/LO writes:
  - MTHI: whilo_o=1, hi_o=reg1, lo_o=lo_i.
  - MTLO: whilo_o=1, hi_o=hi_i, lo_o=reg1.
  - DIV/DIVU: whilo_o=1 only in the DONE cycle, with hi_o=remainder and lo_o=quotient.
  - Otherwise: whilo_o=0, hi_o=0, lo_o=0.
- Divider FSM states: IDLE, BUSY, DONE. Reset puts it in IDLE with count=0 and all datapath registers 0.
- IDLE:
  - On DIV/DIVU with flush=0, latch operand magnitudes (signed ops use absolute values) and both sign bits; stallreq=1.
  - Divisor nonzero: go to BUSY, count=0.
  - Divisor zero: go to DONE with quotient=32'hFFFFFFFF and remainder=reg1_i raw.
- BUSY:
  - Each cycle: shift the remainder left by one and bring in the next dividend bit. If the remainder ≥ the divisor, subtract the divisor and set the quotient bit.
  - stallreq=1. count increments. When count = DIV_CYCLES-1, go to DONE.
- DONE:
  - Signed sign correction: quotient is negated if the dividend and divisor signs differ. Remainder takes the dividend's sign.
  - stallreq=0 and whilo_o=1. Go to IDLE unconditionally the next cycle.
  - Stall timing for a normal divide: the instruction enters at cycle T; stallreq is high T..T+32 (33 cycles); the result is valid at T+33.
- Divide by zero: stallreq is high for 1 cycle and the result is valid at T+1.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): quotient=0x80000000, remainder=0. No trap.
- flush=1: in any state, return to IDLE next edge. stallreq and whilo_o are forced to 0 in that same cycle (combinationally), and no HI/LO write occurs.
- rst=1 at any time (including mid-divide):
  - All outputs 0 immediately and asynchronously.
  - FSM returns to IDLE, so no stale DONE occurs after release.
- A DIV arriving while not in IDLE is impossible because stallreq holds it. If it occurs, ignore the new operands until IDLE.

Test Plan:
- Reset: rst pulsed mid-BUSY at count 10 → all outputs 0 at once; after release, state is IDLE with no whilo_o pulse.
- ALU: ADDU 0xFFFFFFFF+1 → wdata 0. SLT -1,1 → 1. SLTU -1,1 → 0. SRA shamt 4 on 0x80000000 → 0xF8000000. JUMP_BRANCH link 0x1008 → wdata 0x1008.
- DIVU 100/7 at T → stallreq high T..T+32; at T+33 whilo_o=1, lo_o=14, hi_o=2; stallreq low.
- DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV 5/0 → one stall cycle; at T+1 lo_o=0xFFFFFFFF, hi_o=5.
- Flush at T+12 of a divide → stallreq 0 that cycle, no whilo_o; a following DIVU 9/3 completes normally with lo_o=3, hi_o=0.
